// File: rtl/shift_load_ctrl.sv
// Sequencer for a 32-bit shift/load register: loads a word, then issues N single-bit shifts.
// Latency: done is high in cycle 2+N, counting the start cycle as cycle 0 (LOAD is 1 cycle, SHIFT is N cycles, DONE is 1 cycle).
// Backpressure: start is taken only while ready (IDLE, not in reset); any other start is dropped, with no queuing.
//
// Ports:
//   clk, reset        rising-edge clock; synchronous active-high reset
//   start, ready      request handshake; load_data/shift_count are sampled on the accept edge
//   serial_in         bit shifted into the register LSB on each shift cycle
//   reg_state         feedback from the shift register
//   reg_load/reg_sel/reg_shiftin  drive the shift register (sel: 1 = load, 0 = shift)
//   busy, bit_out, bit_valid, done  status and serial output stream
//   rotate            present only when SHIFT_LOAD_CTRL_ROTATE_EN is defined; feeds the MSB back to the LSB
module shift_load_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SHIFT_LOAD_CTRL_ROTATE_EN
  input  logic             rotate,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] shift_count,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] reg_state,
  output logic [WIDTH-1:0] reg_load,
  output logic             reg_sel,
  output logic             reg_shiftin,
  output logic             ready,
  output logic             busy,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             shift_src;

`ifdef SHIFT_LOAD_CTRL_ROTATE_EN
  logic rot_q;

  // Rotating feeds the outgoing MSB back in, so WIDTH shifts restore the word.
  assign shift_src = rot_q ? reg_state[WIDTH-1] : serial_in;
`else
  assign shift_src = serial_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      data_q <= '0;
      cnt_q  <= '0;
`ifdef SHIFT_LOAD_CTRL_ROTATE_EN
      rot_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            data_q <= load_data;
            // Counts beyond the register width are clamped.
            cnt_q  <= (shift_count > MAX_CNT) ? MAX_CNT : shift_count;
`ifdef SHIFT_LOAD_CTRL_ROTATE_EN
            rot_q  <= rotate;
`endif
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          state <= (cnt_q != '0) ? S_SHIFT : S_DONE;
        end
        S_SHIFT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The register has no hold mode, so every non-shift cycle reloads its own
  // state. That includes reset, so the register's own reset wins.
  always_comb begin
    reg_sel     = 1'b1;
    reg_load    = reg_state;
    reg_shiftin = 1'b0;
    ready       = 1'b0;
    busy        = 1'b0;
    bit_valid   = 1'b0;
    done        = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE: begin
          ready = 1'b1;
        end
        S_LOAD: begin
          busy     = 1'b1;
          reg_load = data_q;
        end
        S_SHIFT: begin
          busy        = 1'b1;
          reg_sel     = 1'b0;
          reg_shiftin = shift_src;
          bit_valid   = 1'b1;
        end
        S_DONE: begin
          done = 1'b1;
        end
        default: begin
          ready = 1'b0;
        end
      endcase
    end
  end

  // Show the pre-shift MSB, i.e. the bit leaving on this shift.
  assign bit_out = reg_state[WIDTH-1];

endmodule
